// File: rtl/led_cmd_if.sv
// Command handshake bundle between a command source and the LED link serializer.
// Carries the valid/ready pair plus the 3-bit state and 5-bit LED address fields.
interface led_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_state;
    logic [4:0] cmd_addr;

    modport master (
        output cmd_valid,
        output cmd_state,
        output cmd_addr,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_state,
        input  cmd_addr,
        output cmd_ready
    );
endinterface

// File: rtl/led_cmd_serializer.sv
// Buffers LED commands in a small FIFO and shifts each out as an 8-bit
// CLK/DATA/LATCH frame, MSB first, followed by a latch strobe and a gap.
module led_cmd_serializer #(
    parameter int DIV        = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_LEDS   = 20
) (
    input  logic     CLK,
    input  logic     RESET,
    led_cmd_if.slave cmd,
    output logic     err_addr,
    output logic     busy,
    output logic     SCLK,
    output logic     SDATA,
    output logic     SLATCH
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [5:0] NL = 6'(NUM_LEDS);
    localparam logic [8:0] T_HALF = 9'(DIV - 1);
    localparam logic [8:0] T_LATCH = 9'(2 * DIV - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] BIT_LO = 3'd2;
    localparam logic [2:0] BIT_HI = 3'd3;
    localparam logic [2:0] LATCH  = 3'd4;
    localparam logic [2:0] GAP    = 3'd5;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_n;
    logic          ready_q, err_q;
    logic          hs, in_range, push, pop, empty;

    logic [2:0] state, state_n;
    logic [8:0] tmr, tmr_n;
    logic [2:0] bitc, bitc_n;
    logic [7:0] shreg, shreg_n;
    logic       sending;

    assign cmd.cmd_ready = ready_q;
    assign err_addr      = err_q;

    assign hs       = cmd.cmd_valid & ready_q;
    assign in_range = {1'b0, cmd.cmd_addr} < NL;
    assign push     = hs & in_range;
    assign pop      = (state == LOAD);
    assign empty    = (count == '0);
    assign count_n  = count + CW'(push) - CW'(pop);
    assign busy     = (state != IDLE) | ~empty;

    // ready is registered from the post-update occupancy
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_n;
            ready_q <= (count_n != FULL);
            err_q   <= hs & ~in_range;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {cmd.cmd_state, cmd.cmd_addr};
    end

    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        bitc_n  = bitc;
        shreg_n = shreg;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_n = LOAD;
                    shreg_n = mem[rd_ptr];
                end
            end
            LOAD: begin
                state_n = BIT_LO;
                tmr_n   = T_HALF;
                bitc_n  = 3'd7;
            end
            BIT_LO: begin
                if (tmr == '0) begin
                    state_n = BIT_HI;
                    tmr_n   = T_HALF;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            BIT_HI: begin
                if (tmr != '0) begin
                    tmr_n = tmr - 1'b1;
                end else if (bitc != '0) begin
                    bitc_n  = bitc - 1'b1;
                    shreg_n = {shreg[6:0], 1'b0};
                    state_n = BIT_LO;
                    tmr_n   = T_HALF;
                end else begin
                    state_n = LATCH;
                    tmr_n   = T_LATCH;
                end
            end
            LATCH: begin
                if (tmr == '0) begin
                    state_n = GAP;
                    tmr_n   = T_HALF;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            GAP: begin
                if (tmr == '0) state_n = IDLE;
                else           tmr_n   = tmr - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // pins are registered from the next state so they line up with it
    assign sending = state_n inside {LOAD, BIT_LO, BIT_HI};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            tmr    <= '0;
            bitc   <= '0;
            shreg  <= '0;
            SCLK   <= 1'b0;
            SDATA  <= 1'b0;
            SLATCH <= 1'b0;
        end else begin
            state  <= state_n;
            tmr    <= tmr_n;
            bitc   <= bitc_n;
            shreg  <= shreg_n;
            SCLK   <= (state_n == BIT_HI);
            SDATA  <= sending & shreg_n[7];
            SLATCH <= (state_n == LATCH);
        end
    end
endmodule
